// File: rtl/ov7670_pkg.sv
// Purpose: shared types and QVGA geometry constants for the OV7670 capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the sensor free-runs and the framebuffer always accepts writes.
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    localparam int QVGA_W    = 320;
    localparam int QVGA_H    = 240;
    localparam int FB_DEPTH  = QVGA_W * QVGA_H;   // 76800
    localparam int FB_ADDR_W = 17;
    localparam int PIX_BITS  = 2;

endpackage

// File: rtl/ov7670_capture_core.sv
// Purpose: captures OV7670 QVGA YUV422 (U Y V Y) frames, keeps the top 2 bits of each luma byte.
// Latency: one pclk_12 cycle from luma byte on d to addr/dout.
// Backpressure: none; the framebuffer write port accepts every cycle, addr/dout hold when idle.
//
// Ports:
//   pclk_12        sensor pixel clock, sole clock
//   reset_n        synchronous active-low reset
//   start          level; arms capture, held high for continuous frames
//   vsync/href/d   sensor frame sync, line valid and pixel byte
//   addr/dout      registered framebuffer write address and 2-bit grey level
module ov7670_capture_core
    import ov7670_pkg::*;
#(
    parameter int H_PIXELS = QVGA_W,
    parameter int V_LINES  = QVGA_H,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic                pclk_12,
    input  logic                reset_n,
    input  logic                start,
    input  logic                vsync,
    input  logic                href,
    input  logic [7:0]          d,
    output logic [ADDR_W-1:0]   addr,
    output logic [PIX_BITS-1:0] dout
);

    // Counter is one bit wider than the address so it can sit at the
    // saturation value H_PIXELS*V_LINES without wrapping.
    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(H_PIXELS * V_LINES);

    state_t             state;
    logic [CNT_W-1:0]   pix_cnt;
    logic               phase;     // 0 = chroma byte, 1 = luma byte
    logic               vsync_q;
    logic               vsync_rise;
    logic               vsync_fall;
    logic               unused_d;

    assign vsync_rise = ~vsync_q & vsync;
    assign vsync_fall = vsync_q & ~vsync;

    // Only the top PIX_BITS of luma are stored.
    assign unused_d = ^d[7-PIX_BITS:0];

    always_ff @(posedge pclk_12) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr    <= '0;
            dout    <= '0;
            pix_cnt <= '0;
            phase   <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
            case (state)
                IDLE: begin
                    phase <= 1'b0;
                    if (start) begin
                        state <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    // Only a falling edge starts a frame, so arming mid-frame
                    // never yields a partial frame.
                    phase <= 1'b0;
                    if (vsync_fall) begin
                        pix_cnt <= '0;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // href low realigns each line to start on a chroma byte.
                    phase <= href ? ~phase : 1'b0;
                    if (href && phase && (pix_cnt < PIX_TOTAL)) begin
                        addr    <= pix_cnt[ADDR_W-1:0];
                        dout    <= d[7 -: PIX_BITS];
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                    if (vsync_rise) begin
                        state <= start ? WAIT_FRAME : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture_core.sv
// Purpose: directed self-checking bench for ov7670_capture_core.
// Latency: outputs are sampled 1 time unit after the edge that consumed a byte.
// Backpressure: n/a.
module tb_ov7670_capture_core;

    // Reduced frame height keeps a full frame (plus overflow) well inside the
    // cycle budget: 320 x 8 = 2560 pixels, last address 2559.
    localparam int H = 320;
    localparam int V = 8;
    localparam int AW = 17;
    localparam int LAST_ADDR = H * V - 1;

    logic          pclk_12 = 1'b0;
    logic          reset_n;
    logic          start;
    logic          vsync;
    logic          href;
    logic [7:0]    d;
    logic [AW-1:0] addr;
    logic [1:0]    dout;

    int checks   = 0;
    int failures = 0;

    always #5 pclk_12 = ~pclk_12;

    ov7670_capture_core #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .ADDR_W   (AW)
    ) dut (
        .pclk_12 (pclk_12),
        .reset_n (reset_n),
        .start   (start),
        .vsync   (vsync),
        .href    (href),
        .d       (d),
        .addr    (addr),
        .dout    (dout)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int exp_addr, input int exp_dout);
        check({tag, ".addr"}, int'(addr), exp_addr);
        check({tag, ".dout"}, int'(dout), exp_dout);
    endtask

    // Present one set of sensor inputs for one edge, then settle past it.
    task automatic step(input logic vs, input logic hr, input logic [7:0] dd);
        vsync = vs;
        href  = hr;
        d     = dd;
        @(posedge pclk_12);
        #1;
    endtask

    // One frame boundary: vsync high for two cycles, then low.
    task automatic vsync_pulse();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    // npix chroma/luma pairs followed by one href-low gap cycle.
    task automatic send_line(input int npix, input logic [7:0] luma);
        for (int p = 0; p < npix; p++) begin
            step(1'b0, 1'b1, 8'h5A);
            step(1'b0, 1'b1, luma);
        end
        step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        vsync   = 1'b0;
        href    = 1'b0;
        d       = 8'h00;
        #1;

        // Reset with random inputs on the sensor pins.
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            step(1'($urandom), 1'($urandom), 8'($urandom));
        end
        check_out("reset", 0, 0);

        // Out of reset, start low: sensor activity must not write.
        reset_n = 1'b1;
        start   = 1'b0;
        vsync_pulse();
        send_line(4, 8'hFF);
        vsync_pulse();
        send_line(4, 8'hC0);
        check_out("idle_no_write", 0, 0);

        // Single line: U Y V Y bytes, luma at odd positions.
        start = 1'b1;
        vsync_pulse();
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'hC5);
        check_out("line_px0", 0, 3);
        step(1'b0, 1'b1, 8'h20);
        check_out("line_hold_chroma", 0, 3);
        step(1'b0, 1'b1, 8'h40);
        check_out("line_px1", 1, 1);
        step(1'b0, 1'b1, 8'h30);
        step(1'b0, 1'b1, 8'h80);
        check_out("line_px2", 2, 2);
        step(1'b0, 1'b1, 8'h40);
        step(1'b0, 1'b1, 8'hFF);
        check_out("line_px3", 3, 3);

        // Odd-length burst: href low must realign the next line to chroma.
        step(1'b0, 1'b1, 8'hC0);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        check_out("realign_chroma", 3, 3);
        step(1'b0, 1'b1, 8'h00);
        check_out("realign_luma", 4, 0);
        step(1'b0, 1'b0, 8'h00);

        // Full frame with continuous start: restarts at address 0.
        vsync_pulse();
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'h80);
        check_out("frame_first", 0, 2);
        send_line(H - 1, 8'h80);
        check_out("frame_line0_end", H - 1, 2);
        for (int l = 1; l < V; l++) begin
            send_line(H, 8'h80);
        end
        check_out("frame_last", LAST_ADDR, 2);
        send_line(H, 8'hFF);
        check_out("frame_overflow", LAST_ADDR, 2);

        // Second frame with start held: first luma again lands at 0.
        vsync_pulse();
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'h40);
        check_out("cont_first", 0, 1);

        // Drop start mid-frame: the frame keeps capturing to its end.
        start = 1'b0;
        send_line(3, 8'hC0);
        check_out("stop_mid_frame", 3, 3);

        // Next frame must not be captured.
        vsync_pulse();
        send_line(8, 8'h00);
        check_out("stopped_next_frame", 3, 3);

        // Late start with vsync already low and href active: no capture.
        start = 1'b1;
        send_line(8, 8'h00);
        send_line(8, 8'h40);
        check_out("late_start_wait", 3, 3);
        vsync_pulse();
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'h80);
        check_out("late_start_first", 0, 2);

        // Capture through pixel 100, then reset mid-frame.
        send_line(100, 8'h40);
        check_out("pre_reset_px100", 100, 1);
        reset_n = 1'b0;
        step(1'b0, 1'b1, 8'h5A);
        check_out("mid_reset", 0, 0);
        reset_n = 1'b1;
        send_line(20, 8'hFF);
        check_out("post_reset_no_vsync", 0, 0);
        vsync_pulse();
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'h7F);
        check_out("post_reset_resume", 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
